class_accum_ctrl: RTL

Sequencer for hypervector bundling into the class-counter memory. On a `start` for a given class it walks the 10 chunks of that class's stored counter vector. For each chunk it:
- reads the stored counters;
- accepts one 5-bit input hypervector chunk over a valid/ready handshake;
- adds them through an internal `adder_block` instance;
- writes the 40-bit sum back.

It sits between the encoder output stream and the single-port class memory. It is the only writer of that memory during training.

---
 rtl/class_accum_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/class_accum_ctrl.sv
// Class-counter bundling sequencer: read-modify-write of one hypervector into class memory.
// Optional per-lane saturation at THRESHOLD is enabled by defining HDC_ACC_SAT_EN.

module adder_block #(
  parameter int unsigned LANES  = 5,
  parameter int unsigned LANE_W = 8
) (
  input  logic [LANES*LANE_W-1:0] acc,
  input  logic [LANES-1:0]        inc,
  output logic [LANES*LANE_W-1:0] sum
);

  // Independent per-lane unsigned add; carries never cross lanes.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign sum[k*LANE_W +: LANE_W] = acc[k*LANE_W +: LANE_W] + LANE_W'(inc[k]);
  end

endmodule

module class_accum_ctrl #(
  parameter int unsigned NUM_CHUNKS  = 10,
  parameter int unsigned NUM_CLASSES = 4,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned THRESHOLD   = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        class_id,
  input  logic              in_valid,
  input  logic [4:0]        in_chunk,
  output logic              in_ready,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [39:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [39:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       bundle_cnt
);

  localparam int unsigned LANES  = 5;
  localparam int unsigned LANE_W = 8;
  localparam int unsigned DATA_W = LANES * LANE_W;
  localparam int unsigned IDX_W  = $clog2(NUM_CHUNKS);
  localparam int unsigned CLS_W  = 2;
  localparam int unsigned CNT_W  = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

`ifdef HDC_ACC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

  state_t             state;
  logic [CLS_W-1:0]   cls;
  logic [IDX_W-1:0]   idx;
  logic [LANES-1:0]   chunk;
  logic [LANES-1:0]   sat_mask;
  logic [LANES-1:0]   inc;
  logic [DATA_W-1:0]  sum;

  function automatic logic [ADDR_W-1:0] chunk_addr(input logic [CLS_W-1:0] c,
                                                   input logic [IDX_W-1:0] i);
    return ADDR_W'(32'(c) * NUM_CHUNKS + 32'(i));
  endfunction

  // A lane already at the ceiling refuses further increments.
  for (genvar k = 0; k < LANES; k++) begin : g_sat
    assign sat_mask[k] = (32'(mem_rdata[k*LANE_W +: LANE_W]) < THRESHOLD);
  end

  assign inc = SAT_EN ? (chunk & sat_mask) : chunk;

  adder_block #(
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_adder (
    .acc (mem_rdata),
    .inc (inc),
    .sum (sum)
  );

  // Read data arrives in the WRITE cycle itself, so the write data is combinational.
  assign mem_wdata = mem_wr_en ? sum : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cls        <= '0;
      idx        <= '0;
      chunk      <= '0;
      in_ready   <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_wr_en  <= 1'b0;
      mem_addr   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      bundle_cnt <= '0;
    end else begin
      err  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (32'(class_id) < NUM_CLASSES) begin
              cls       <= class_id;
              idx       <= '0;
              state     <= FETCH;
              busy      <= 1'b1;
              in_ready  <= 1'b1;
              mem_rd_en <= 1'b1;
              mem_addr  <= chunk_addr(class_id, '0);
            end else begin
              err <= 1'b1;
            end
          end
        end
        FETCH: begin
          // Read is reissued every waiting cycle, so the data seen in WRITE is fresh.
          if (in_valid) begin
            chunk     <= in_chunk;
            state     <= WRITE;
            in_ready  <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b1;
          end
        end
        WRITE: begin
          mem_wr_en <= 1'b0;
          if (idx == LAST_IDX) begin
            state    <= DONE;
            done     <= 1'b1;
            mem_addr <= '0;
            if (bundle_cnt != {CNT_W{1'b1}}) begin
              bundle_cnt <= bundle_cnt + CNT_W'(1);
            end
          end else begin
            idx       <= idx + IDX_W'(1);
            state     <= FETCH;
            in_ready  <= 1'b1;
            mem_rd_en <= 1'b1;
            mem_addr  <= chunk_addr(cls, idx + IDX_W'(1));
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
